// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage in front of the 16-bit ALU: instruction handshake,
// 8-entry register file, operand/opcode drive, result capture and writeback.
module alu_issue_ctrl #(
   parameter int unsigned NREGS    = 8,
   parameter int unsigned DW       = 16,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_instr,
   input  logic          ext_we,
   input  logic [2:0]    ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic [2:0]    alu_opcode,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_result,
   output logic          wb_valid,
   output logic [2:0]    wb_addr,
   output logic [DW-1:0] wb_data,
   output logic          busy
);

   localparam int unsigned AW  = 3;
   localparam int unsigned OPW = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [AW-1:0]  rd;
      logic [AW-1:0]  rs1;
      logic [AW-1:0]  rs2;
      logic [3:0]     spare;
   } instr_t;

   state_t         state_q;
   state_t         state_d;
   logic           accept_c;
   logic           load_ops_c;
   logic           load_res_c;
   logic           wb_c;

   instr_t         instr_c;
   logic [3:0]     unused_spare;

   logic [OPW-1:0] op_q;
   logic [AW-1:0]  rd_q;
   logic [AW-1:0]  rs1_q;
   logic [AW-1:0]  rs2_q;
   logic [DW-1:0]  res_q;

   logic [DW-1:0]  rf [NREGS];
   logic [DW-1:0]  opnd_a_c;
   logic [DW-1:0]  opnd_b_c;

   assign instr_c      = instr_t'(in_instr);
   assign unused_spare = instr_c.spare;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-stage enables
   always_comb begin
      state_d    = state_q;
      accept_c   = 1'b0;
      load_ops_c = 1'b0;
      load_res_c = 1'b0;
      wb_c       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               accept_c = 1'b1;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            load_ops_c = 1'b1;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            load_res_c = 1'b1;
            state_d    = S_WB;
         end
         S_WB: begin
            wb_c    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake/status flags track the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         in_ready <= (state_d == S_IDLE);
         busy     <= (state_d != S_IDLE);
      end
   end

   // Instruction fields held for the duration of the sequence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         rd_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
      end else if (accept_c) begin
         op_q  <= instr_c.op;
         rd_q  <= instr_c.rd;
         rs1_q <= instr_c.rs1;
         rs2_q <= instr_c.rs2;
      end
   end

   assign opnd_a_c = (ZERO_REG && (rs1_q == '0)) ? '0 : rf[rs1_q];
   assign opnd_b_c = (ZERO_REG && (rs2_q == '0)) ? '0 : rf[rs2_q];

   // ALU drive; held between instructions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else if (load_ops_c) begin
         alu_opcode <= op_q;
         alu_a      <= opnd_a_c;
         alu_b      <= opnd_b_c;
      end
   end

   // Single sample of the combinational ALU result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (load_res_c) begin
         res_q <= alu_result;
      end
   end

   // Writeback status: one-cycle pulse, address/data held afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= wb_c;
         if (wb_c) begin
            wb_addr <= rd_q;
            wb_data <= res_q;
         end
      end
   end

   // Register file: writeback has priority over the external port on the same entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (!(ZERO_REG && (i == 0))) begin
               if (wb_c && (rd_q == AW'(i))) begin
                  rf[i] <= res_q;
               end else if (ext_we && (ext_addr == AW'(i))) begin
                  rf[i] <= ext_wdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-op ALU on the result input.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        ext_we;
   logic [2:0]  ext_addr;
   logic [15:0] ext_wdata;
   logic [2:0]  alu_opcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        busy;

   int tests = 0;
   int fails = 0;

   alu_issue_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 mul (low 16 bits)
   always_comb begin
      case (alu_opcode)
         3'd0:    alu_result = alu_a + alu_b;
         3'd1:    alu_result = alu_a - alu_b;
         3'd2:    alu_result = alu_a & alu_b;
         3'd3:    alu_result = alu_a | alu_b;
         3'd4:    alu_result = alu_a ^ alu_b;
         3'd5:    alu_result = alu_a << alu_b[3:0];
         3'd6:    alu_result = alu_a >> alu_b[3:0];
         default: alu_result = alu_a * alu_b;
      endcase
   end

   int          cyc = 0;
   int          acc_n = 0;
   int          acc_cyc [8];
   int          wb_count = 0;
   logic [18:0] wb_log [$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (in_valid && in_ready && rst_n) begin
         if (acc_n < 8) acc_cyc[acc_n] = cyc;
         acc_n = acc_n + 1;
      end
      if (wb_valid) begin
         wb_count = wb_count + 1;
         wb_log.push_back({wb_addr, wb_data});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic ext_load(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      ext_we    = 1'b1;
      ext_addr  = a;
      ext_wdata = d;
      @(negedge clk);
      ext_we    = 1'b0;
   endtask

   task automatic issue(input logic [15:0] ins, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = ins;
      for (int n = 0; n < 20; n++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready never rose for instr 0x%0h", ins);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_instr(input string nm, input logic [2:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2,
                            input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] er,
                            input bit inj, input logic [2:0] ia, input logic [15:0] idat);
      bit ok;
      issue({op, rd, rs1, rs2, 4'h0}, ok);
      if (!ok) return;
      @(posedge clk);
      #1;
      chk({nm, " opcode"}, 32'(alu_opcode), 32'(op));
      chk({nm, " alu_a"}, 32'(alu_a), 32'(ea));
      chk({nm, " alu_b"}, 32'(alu_b), 32'(eb));
      chk({nm, " busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (inj) begin
         ext_we    = 1'b1;
         ext_addr  = ia;
         ext_wdata = idat;
      end
      @(posedge clk);
      #1;
      chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
      chk({nm, " wb_addr"}, 32'(wb_addr), 32'(rd));
      chk({nm, " wb_data"}, 32'(wb_data), 32'(er));
      chk({nm, " in_ready_after_wb"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      ext_we = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, " wb_pulse_end"}, 32'(wb_valid), 32'd0);
   endtask

   // Observe a register through operand A of an ADD into r0
   task automatic read_reg(input string nm, input logic [2:0] a, input logic [15:0] exp);
      run_instr(nm, 3'd0, 3'd0, a, 3'd0, exp, 16'h0000, exp, 1'b0, 3'd0, 16'h0000);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
   } vec_t;

   vec_t vecs [9];

   initial begin
      bit          ok;
      int          base;
      int          low_cnt;
      int          snap;
      logic [18:0] e;

      vecs[0] = '{"add",      3'd0, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0007, 16'h000C};
      vecs[1] = '{"sub_wrap", 3'd1, 3'd3, 3'd1, 3'd2, 16'h0003, 16'h0005, 16'hFFFE};
      vecs[2] = '{"mul_wrap", 3'd7, 3'd3, 3'd1, 3'd2, 16'h0100, 16'h0100, 16'h0000};
      vecs[3] = '{"shl",      3'd5, 3'd3, 3'd1, 3'd2, 16'h8001, 16'h0001, 16'h0002};
      vecs[4] = '{"and",      3'd2, 3'd1, 3'd4, 3'd5, 16'hF0F0, 16'h3C3C, 16'h3030};
      vecs[5] = '{"xor",      3'd4, 3'd2, 3'd6, 3'd7, 16'hFFFF, 16'h1234, 16'hEDCB};
      vecs[6] = '{"or",       3'd3, 3'd6, 3'd4, 3'd5, 16'h00F0, 16'h0F00, 16'h0FF0};
      vecs[7] = '{"shr",      3'd6, 3'd5, 3'd1, 3'd2, 16'h8000, 16'h0003, 16'h1000};
      vecs[8] = '{"add_carry",3'd0, 3'd7, 3'd6, 3'd6, 16'h8000, 16'h8000, 16'h0000};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 16'h0000;
      ext_we    = 1'b0;
      ext_addr  = 3'd0;
      ext_wdata = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst wb_valid", 32'(wb_valid), 32'd0);
      chk("rst wb_addr", 32'(wb_addr), 32'd0);
      chk("rst wb_data", 32'(wb_data), 32'd0);
      chk("rst alu_opcode", 32'(alu_opcode), 32'd0);
      chk("rst alu_a", 32'(alu_a), 32'd0);
      chk("rst alu_b", 32'(alu_b), 32'd0);

      for (int i = 0; i < 9; i++) begin
         ext_load(vecs[i].rs1, vecs[i].a);
         ext_load(vecs[i].rs2, vecs[i].b);
         run_instr(vecs[i].name, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].a, vecs[i].b, vecs[i].res, 1'b0, 3'd0, 16'h0000);
         read_reg({vecs[i].name, " rd_readback"}, vecs[i].rd, vecs[i].res);
      end

      // Two queued instructions with in_valid held high; second depends on first
      ext_load(3'd1, 16'h0005);
      ext_load(3'd2, 16'h0007);
      base    = acc_n;
      snap    = wb_count;
      low_cnt = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = {3'd0, 3'd3, 3'd1, 3'd2, 4'h0};
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (acc_n == base + 1) begin
            in_instr = {3'd0, 3'd4, 3'd3, 3'd1, 4'h0};
            if (!in_ready) low_cnt++;
         end
         if (acc_n >= base + 2) break;
      end
      in_valid = 1'b0;
      chk("hs accepts", 32'(acc_n - base), 32'd2);
      chk("hs ready_low_cycles", 32'(low_cnt), 32'd3);
      if (acc_n - base >= 2 && base + 1 < 8)
         chk("hs accept_spacing", 32'(acc_cyc[base+1] - acc_cyc[base]), 32'd4);
      repeat (6) @(negedge clk);
      chk("hs wb_count", 32'(wb_count - snap), 32'd2);
      if (wb_log.size() >= 2) begin
         e = wb_log[wb_log.size()-2];
         chk("hs wb1", 32'(e), 32'({3'd3, 16'h000C}));
         e = wb_log[wb_log.size()-1];
         chk("hs wb2_dependent", 32'(e), 32'({3'd4, 16'h0011}));
      end

      // r0 behaviour
      run_instr("r0 dest", 3'd0, 3'd0, 3'd1, 3'd2, 16'h0005, 16'h0007, 16'h000C,
                1'b0, 3'd0, 16'h0000);
      read_reg("r0 after wb", 3'd0, 16'h0000);
      ext_load(3'd0, 16'hFFFF);
      read_reg("r0 after ext", 3'd0, 16'h0000);

      // Ext write colliding with writeback
      ext_load(3'd1, 16'h1000);
      ext_load(3'd2, 16'h0234);
      run_instr("coll same", 3'd0, 3'd3, 3'd1, 3'd2, 16'h1000, 16'h0234, 16'h1234,
                1'b1, 3'd3, 16'hAAAA);
      read_reg("coll same r3", 3'd3, 16'h1234);
      ext_load(3'd3, 16'h0000);
      run_instr("coll diff", 3'd0, 3'd3, 3'd1, 3'd2, 16'h1000, 16'h0234, 16'h1234,
                1'b1, 3'd4, 16'hAAAA);
      read_reg("coll diff r3", 3'd3, 16'h1234);
      read_reg("coll diff r4", 3'd4, 16'hAAAA);

      // Asynchronous reset while in EXEC
      ext_load(3'd1, 16'h0005);
      ext_load(3'd2, 16'h0007);
      snap = wb_count;
      issue({3'd0, 3'd3, 3'd1, 3'd2, 4'h0}, ok);
      @(posedge clk);
      @(negedge clk);
      chk("rstx in_exec_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstx in_ready", 32'(in_ready), 32'd1);
      chk("rstx busy", 32'(busy), 32'd0);
      chk("rstx wb_valid", 32'(wb_valid), 32'd0);
      chk("rstx alu_a", 32'(alu_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rstx no_wb", 32'(wb_count - snap), 32'd0);
      read_reg("rstx r1", 3'd1, 16'h0000);
      read_reg("rstx r2", 3'd2, 16'h0000);
      read_reg("rstx r3", 3'd3, 16'h0000);
      read_reg("rstx r4", 3'd4, 16'h0000);
      ext_load(3'd1, 16'h0002);
      ext_load(3'd2, 16'h0003);
      run_instr("rstx next", 3'd0, 3'd5, 3'd1, 3'd2, 16'h0002, 16'h0003, 16'h0005,
                1'b0, 3'd0, 16'h0000);
      read_reg("rstx next r5", 3'd5, 16'h0005);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
